// File: rtl/uart_tx_asm_if.sv
// Parallel-side handshake and serial-side status bundle for the UART transmitter.
interface uart_tx_asm_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  parity_per_byte;
  logic                  tx_ready;
  logic                  tx_out;
  logic                  busy;
  logic                  done;

  modport master (
    output tx_valid, tx_data, parity_per_byte,
    input  tx_ready, tx_out, busy, done
  );

  modport slave (
    input  tx_valid, tx_data, parity_per_byte,
    output tx_ready, tx_out, busy, done
  );
endinterface

// File: rtl/uart_tx_asm.sv
// UART transmitter, one bit per clk, even parity per frame or per byte, with a
// single-entry holding register so consecutive frames leave no idle gap.
module uart_tx_asm #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_asm_if.slave  bus_io
);

  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("uart_tx_asm: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 4) begin : g_bad_stop
    $error("uart_tx_asm: STOP_BITS must be in 1..4");
  end

  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_ppb_q, hold_ppb_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  mode_q, mode_d;
  logic                  par_q, par_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [1:0]            stop_cnt_q, stop_cnt_d;
  logic                  tx_out_q, tx_out_d;
  logic                  done_q, done_d;

  logic            accept, load, last_stop, data_end, more_bytes;
  logic [CntW-1:0] byte_nxt;

  assign accept     = bus_io.tx_valid && !hold_full_q;
  assign last_stop  = (stop_cnt_q == 2'(STOP_BITS - 1));
  assign byte_nxt   = byte_cnt_q + CntW'(1);
  assign more_bytes = (byte_nxt < CntW'(DATA_WIDTH / 8));
  assign data_end   = (mode_q && (bit_cnt_q[2:0] == 3'd7)) ||
                      (bit_cnt_q == CntW'(DATA_WIDTH - 1));
  // Holding register empties into the shifter from IDLE or from the last stop cycle.
  assign load       = hold_full_q &&
                      ((state_q == StIdle) || ((state_q == StStop) && last_stop));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (hold_full_q) state_d = StStart;
      StStart:  state_d = StData;
      StData:   if (data_end) state_d = StParity;
      StParity: state_d = (mode_q && more_bytes) ? StData : StStop;
      StStop:   if (last_stop) state_d = hold_full_q ? StStart : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    hold_d      = hold_q;
    hold_ppb_d  = hold_ppb_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    mode_d      = mode_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    stop_cnt_d  = stop_cnt_q;

    if (load) begin
      hold_full_d = 1'b0;
      shift_d     = hold_q;
      mode_d      = hold_ppb_q;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_d      = bus_io.tx_data;
      hold_ppb_d  = bus_io.parity_per_byte;
    end

    case (state_q)
      StStart: begin
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        par_d      = 1'b0;
      end
      StData: begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + CntW'(1);
        par_d     = par_q ^ shift_q[0];
      end
      StParity: begin
        // Per-byte mode restarts the parity accumulator for the next byte.
        par_d      = 1'b0;
        stop_cnt_d = '0;
        if (mode_q && more_bytes) byte_cnt_d = byte_nxt;
      end
      StStop:  stop_cnt_d = stop_cnt_q + 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      hold_ppb_q  <= 1'b0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      mode_q      <= 1'b0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      stop_cnt_q  <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_ppb_q  <= hold_ppb_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      mode_q      <= mode_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
    end
  end

  // Output logic; tx_out and done are registered so done lines up with the last stop bit.
  always_comb begin
    tx_out_d = 1'b1;
    done_d   = 1'b0;
    case (state_q)
      StStart:  tx_out_d = 1'b0;
      StData:   tx_out_d = shift_q[0];
      StParity: tx_out_d = par_q;
      StStop:   done_d   = last_stop;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_out_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      tx_out_q <= tx_out_d;
      done_q   <= done_d;
    end
  end

  assign bus_io.tx_out   = tx_out_q;
  assign bus_io.done     = done_q;
  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.tx_ready = !hold_full_q;

endmodule

// File: tb/tb_uart_tx_asm.sv
// Directed bench for uart_tx_asm: frame shapes, parity modes, back-to-back, reset, stop bits.
module tb_uart_tx_asm;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   sel   = 0;

  uart_tx_asm_if #(.DATA_WIDTH(8))  if8 ();
  uart_tx_asm_if #(.DATA_WIDTH(16)) if16 ();
  uart_tx_asm_if #(.DATA_WIDTH(8))  if8s ();

  uart_tx_asm #(.DATA_WIDTH(8),  .STOP_BITS(1)) u_dut8  (.clk(clk), .rst(rst), .bus_io(if8));
  uart_tx_asm #(.DATA_WIDTH(16), .STOP_BITS(1)) u_dut16 (.clk(clk), .rst(rst), .bus_io(if16));
  uart_tx_asm #(.DATA_WIDTH(8),  .STOP_BITS(3)) u_dut8s (.clk(clk), .rst(rst), .bus_io(if8s));

  always #5 clk = ~clk;

  logic obs_tx, obs_busy, obs_done, obs_ready;
  always_comb begin
    obs_tx    = if8.tx_out;
    obs_busy  = if8.busy;
    obs_done  = if8.done;
    obs_ready = if8.tx_ready;
    case (sel)
      1: begin
        obs_tx = if16.tx_out; obs_busy = if16.busy; obs_done = if16.done; obs_ready = if16.tx_ready;
      end
      2: begin
        obs_tx = if8s.tx_out; obs_busy = if8s.busy; obs_done = if8s.done; obs_ready = if8s.tx_ready;
      end
      default: ;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic ppb);
    case (sel)
      1:       begin if16.tx_valid = v; if16.tx_data = d;      if16.parity_per_byte = ppb; end
      2:       begin if8s.tx_valid = v; if8s.tx_data = d[7:0]; if8s.parity_per_byte = ppb; end
      default: begin if8.tx_valid  = v; if8.tx_data  = d[7:0]; if8.parity_per_byte  = ppb; end
    endcase
  endtask

  // Checks one tx_out/done character per cycle, starting at the current cycle.
  task automatic stream(input string tag, input string bits, input string dones,
                        output int nbusy, output int ndone);
    nbusy = 0;
    ndone = 0;
    for (int k = 0; k < bits.len(); k++) begin
      chk($sformatf("%s tx[%0d]", tag, k), 16'(obs_tx), 16'(bits[k] == "1"));
      chk($sformatf("%s done[%0d]", tag, k), 16'(obs_done), 16'(dones[k] == "1"));
      if (obs_busy) nbusy++;
      if (obs_done) ndone++;
      tick;
    end
  endtask

  // Isolated frame from IDLE: accept, one load cycle, START cycle, then the serial bits.
  task automatic frame(input string tag, input logic [15:0] d, input logic ppb, input string bits);
    string dn;
    int    nb, nd;
    dn = "";
    for (int k = 0; k < bits.len(); k++) dn = {dn, (k == bits.len() - 1) ? "1" : "0"};
    drive(1'b1, d, ppb);
    tick;
    drive(1'b0, ~d, ~ppb);
    chk({tag, " ready after accept"}, 16'(obs_ready), 16'd0);
    tick;
    chk({tag, " busy at start"}, 16'(obs_busy), 16'd1);
    chk({tag, " ready after load"}, 16'(obs_ready), 16'd1);
    tick;
    stream(tag, bits, dn, nb, nd);
    chk({tag, " busy cycles"}, 16'(nb + 1), 16'(bits.len()));
    chk({tag, " done pulses"}, 16'(nd), 16'd1);
  endtask

  initial begin
    int nb, nd, nd2;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      drive(1'b0, 16'h0, 1'b0);
    end
    sel = 0;
    tick;
    tick;
    chk("reset tx_out", 16'(obs_tx), 16'd1);
    chk("reset busy", 16'(obs_busy), 16'd0);
    chk("reset done", 16'(obs_done), 16'd0);
    chk("reset ready", 16'(obs_ready), 16'd1);
    rst = 1'b0;
    tick;

    frame("a5", 16'h00A5, 1'b0, "01010010101");

    // Back-to-back with tx_valid held high
    drive(1'b1, 16'h01, 1'b0);
    tick;
    chk("b2b ready held", 16'(obs_ready), 16'd0);
    drive(1'b1, 16'hFF, 1'b0);
    tick;
    chk("b2b ready after load", 16'(obs_ready), 16'd1);
    tick;
    drive(1'b0, 16'h00, 1'b0);
    chk("b2b ready second held", 16'(obs_ready), 16'd0);
    stream("b2b1", "0100000001", "0000000000", nb, nd);
    chk("b2b ready at stop", 16'(obs_ready), 16'd1);
    stream("b2b2", "101111111101", "100000000001", nb, nd2);
    chk("b2b done pulses", 16'(nd + nd2), 16'd2);

    // Accept during last stop cycle with empty holding register
    drive(1'b1, 16'h01, 1'b0);
    tick;
    drive(1'b0, 16'h00, 1'b0);
    tick;
    tick;
    stream("ls1", "010000000", "000000000", nb, nd);
    drive(1'b1, 16'h0F, 1'b0);
    stream("ls2", "1", "0", nb, nd);
    drive(1'b0, 16'h00, 1'b0);
    stream("ls3", "1101111000001", "1000000000001", nb, nd);

    // Reset mid-frame, with a word waiting in the holding register
    drive(1'b1, 16'h55, 1'b0);
    tick;
    drive(1'b0, 16'h00, 1'b0);
    tick;
    tick;
    stream("r55", "010", "000", nb, nd);
    drive(1'b1, 16'h99, 1'b0);
    stream("r55b", "1", "0", nb, nd);
    drive(1'b0, 16'h00, 1'b0);
    chk("r55 bit3", 16'(obs_tx), 16'd0);
    chk("r55 held", 16'(obs_ready), 16'd0);
    rst = 1'b1;
    #1;
    chk("rst async tx_out", 16'(obs_tx), 16'd1);
    chk("rst async busy", 16'(obs_busy), 16'd0);
    chk("rst async ready", 16'(obs_ready), 16'd1);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("post-rst idle tx", 16'(obs_tx), 16'd1);
      chk("post-rst idle busy", 16'(obs_busy), 16'd0);
      chk("post-rst ready", 16'(obs_ready), 16'd1);
    end
    frame("3c", 16'h003C, 1'b0, "00011110001");

    sel = 1;
    tick;
    frame("pb16", 16'h03C1, 1'b1, "01000001111100000001");
    frame("sp16", 16'h03C1, 1'b0, "0100000111100000011");

    sel = 2;
    tick;
    frame("sb3", 16'h0080, 1'b0, "0000000011111");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_asm.md
Name: uart_tx_asm

Overview:
- Serial UART transmitter. It is the upstream partner of the team's receiver block: it generates the exact frame that receiver samples, at one bit per clk (no oversampling).
- Accepts parallel words over a valid/ready handshake and holds one word in a single-entry holding register, so back-to-back frames go out with no idle gap.
- Serialises each word LSB-first with even parity, either one parity bit per frame or one parity bit after every byte.

Parameters:
- DATA_WIDTH, 8, payload bits per frame. Must be a multiple of 8 and at least 8; enforced by an elaboration-time check.
- STOP_BITS, 1, number of stop-bit cycles driven high per frame. Legal range is 1 to 4.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- tx_valid  input  1  tx_data is offered for transfer
- tx_data  input  DATA_WIDTH  word to transmit
- parity_per_byte  input  1  1 = parity bit after each byte; 0 = single parity bit after the last data bit. Sampled together with tx_data.
- tx_ready  output  1  holding register is empty
- tx_out  output  1  serial line; idles high
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse on the final stop-bit cycle

Behaviour:
- Reset: asynchronous and active-high. The reset is fixed; it is not selectable.
  - While rst is high: tx_out=1, busy=0, done=0, tx_ready=1, holding register empty, state IDLE.
  - Asserting rst mid-frame aborts the frame immediately and discards any held word.
- tx_out is registered. Parity bit = XOR of the covered data bits (even parity).
- Handshake:
  - Transfer occurs on a rising edge where tx_valid && tx_ready.
  - tx_ready = !hold_full.
  - On transfer, tx_data and parity_per_byte are captured into the holding register.
  - tx_data is ignored when no transfer occurs.
- States:
  - IDLE: tx_out=1. If hold_full, then next edge: move to START, load the shifter from the holding register, hold_full<=0.
  - START: tx_out=0 for one cycle; bit_cnt=0, byte_cnt=0. Next state is DATA.
  - DATA: tx_out = shifter[0]; shift right; bit_cnt++. Exits to PARITY when either:
    - per-byte mode and bit_cnt[2:0]==7, or
    - bit_cnt==DATA_WIDTH-1.
  - PARITY: tx_out = XOR of the byte just sent (per-byte mode) or of the whole word (single mode). The parity value is precomputed at load time, or accumulated as bits are sent. Then:
    - per-byte mode with (byte_cnt+1)*8 < DATA_WIDTH: byte_cnt++ and return to DATA;
    - otherwise go to STOP.
  - STOP: tx_out=1 for STOP_BITS cycles. done=1 on the last of them. After the last cycle:
    - if hold_full, go straight to START (loading as in IDLE);
    - otherwise go to IDLE.
- busy = (state != IDLE).
- Latency: a word accepted at edge N in IDLE produces its start bit on tx_out in the cycle after edge N+2. That is one edge to load the holding register, one to enter START.
- Frame length in cycles: 1 + DATA_WIDTH + P + STOP_BITS, where P = DATA_WIDTH/8 in per-byte mode, else 1.
- Simultaneous events:
  - An accept during the last STOP cycle is legal only if the holding register was empty. The new word is then sent after one IDLE cycle.
  - If the holding register was full, its word is loaded at that edge and tx_ready rises the next cycle.
- The mode of the frame in flight is fixed at load; changing parity_per_byte mid-frame has no effect on it.

Test Plan:
- Single-parity byte: DATA_WIDTH=8, STOP_BITS=1, send 0xA5 with parity_per_byte=0 -> tx_out = 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, parity 0, stop); done pulses on the stop cycle; busy high for exactly 11 cycles.
- Per-byte parity: DATA_WIDTH=16, send 0x03C1 with parity_per_byte=1 -> tx_out = 0, 1,0,0,0,0,0,1,1, parity 1, 1,1,0,0,0,0,0,0, parity 0, 1.
- Back-to-back: DATA_WIDTH=8, STOP_BITS=1, tx_valid held high with 0x01 then 0xFF -> second start bit directly follows the first frame's stop bit; tx_ready low while the holding register is full; exactly 2 done pulses.
- Reset mid-frame: assert rst during data bit 3 of 0x55 -> tx_out=1 and busy=0 asynchronously (before the next edge); tx_ready=1 after release; a new word 0x3C then transmits correctly.
- Loopback: tx_out drives the receiver's rx_in (receiver rst_n = !rst), same clk, 100 random words in both parity modes, DATA_WIDTH 8 and 16 -> receiver valid pulses once per word, data matches, error=0.
- Stop bits: STOP_BITS=3, send 0x80 -> tx_out high for 3 cycles after parity bit 1; done only on the third stop cycle.
